jump_sequencer: RTL and testbench
=================================

# jump_sequencer

Frame-paced vertical-motion sequencer for the player character. Converts the space key into a charged jump and runs the rise → peak → fall → land arc, with a signed per-frame Y step that the character position register adds once per frame. Sits between the keyboard keycode decode and the character position datapath, replacing fixed-velocity jump/fall states with a counter-driven arc.

## Interface
Parameters:
- V_MIN, 4: base launch speed, pixels/frame.
- CHARGE_MAX, 15: charge saturation, frames; V_MIN+CHARGE_MAX ≤ 31.
- PEAK_HOLD, 3: zero-motion frames at apex; 1..15.
- V_TERM, 8: terminal fall speed, pixels/frame; 1..31.

Ports:
- CLK  in  1  system clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- space  in  1  level; 1 while keycode0 == 8'h44.
- on_ground  in  1  level; 1 when Char_Y_Pos + Char_Size ≥ Char_Y_Max.
- y_motion  out  10  two's-complement Y step; negative means up.
- step_valid  out  1  one-cycle pulse; position adds y_motion this cycle.
- land_pulse  out  1  one-cycle pulse on entry to LAND.
- busy  out  1  state ≠ IDLE.
- state_o  out  3  IDLE=0, CHARGE=1, RISE=2, PEAK=3, FALL=4, LAND=5 (HEX debug).
- charge  out  4  current charge count.

## Operation
- Internal: 5-bit unsigned speed v, 4-bit charge, 4-bit hold counter, 1-bit space_q (previous space, for edge detect).
- IDLE: a space rising edge (space & !space_q) with on_ground → CHARGE, charge=0. Else, on a frame_tick with !on_ground → FALL, v=1. A held key never re-triggers.
- CHARGE: each frame_tick with space=1 → charge++, saturating at CHARGE_MAX. No step is emitted. When space=0 on any cycle → RISE, v = V_MIN + charge.
- RISE: each frame_tick emits y_motion = −v, then v−1. When the emitted v was 1 → PEAK, hold = PEAK_HOLD. on_ground is ignored.
- PEAK: each frame_tick emits y_motion = 0 and decrements hold. When hold reaches 0 → FALL, v=1.
- FALL: on a frame_tick with on_ground=1 → LAND, no step emitted. Otherwise emit y_motion = +v, then v = min(v+1, V_TERM).
- LAND: land_pulse is high on the entry cycle. The next frame_tick emits y_motion = 0 → IDLE, v=0, charge=0.
- Space edges outside IDLE are ignored. No double jump.
- y_motion is v sign-extended or negated to 10 bits. It holds its last value between steps and is consumed only when qualified by step_valid.

## Timing
- Reset values: y_motion=0, step_valid=0, land_pulse=0, busy=0, state_o=0, charge=0, v=0, space_q=0.
- All outputs are registered. A frame_tick at cycle t produces step_valid and y_motion at t+1. State changes at t+1.
- CHARGE exit is one cycle after space falls. The first RISE step waits for the next frame_tick.
- Space release and frame_tick in the same cycle in CHARGE: no increment; launch uses the current charge.
- on_ground and frame_tick in the same cycle in IDLE: no transition.
- reset asserted in any state, including mid-RISE: next cycle is IDLE with reset values. A space held through reset does not launch until released and pressed again.
- Back-to-back frame_ticks are legal; one step per tick.

## Configuration
- JUMP_CHARGE_EN defined: CHARGE state is present as described.
- JUMP_CHARGE_EN undefined: CHARGE state is removed. A space edge in IDLE goes directly to RISE with v = V_MIN. charge is tied to 0. state_o never reads 1.

## Test plan
- Reset with space=1, on_ground=1 → all outputs 0, state_o=0; no launch until space toggles 0→1.
- Defaults. Press space, 2 frame_ticks, release → charge=2, RISE steps −6,−5,−4,−3,−2,−1 (total −21), then 3 zero steps, then FALL +1,+2,… until on_ground → land_pulse, one zero step, IDLE.
- Hold space for 20 frame_ticks → charge saturates at 15. Release → first step −19, 19 rise steps.
- IDLE with on_ground=0 for 12 ticks → steps +1..+8,+8,+8,+8,+8. Raise on_ground → no step on that tick, land_pulse, IDLE after the next tick.
- Assert reset during the third RISE step → next cycle IDLE, y_motion=0, step_valid=0, busy=0.
- JUMP_CHARGE_EN undefined. Press space → RISE on the next cycle. Steps −4,−3,−2,−1, charge stays 0.

Source files
------------

// File: rtl/jump_sequencer.sv
//------------------------------------------------------------------------------
// jump_sequencer
//
// Frame-paced vertical-motion sequencer for the player character. Turns the
// space key into a (optionally charged) jump and runs the rise -> peak ->
// fall -> land arc. It emits one signed Y step per frame, which the character
// position register adds whenever step_valid is high.
//
// Build option: define JUMP_CHARGE_EN to include the CHARGE state. In that
// build, holding space on the ground builds up launch speed one frame at a
// time. Without the macro, a space press launches at V_MIN immediately, and
// charge always reads 0.
//
// Parameters:
//   V_MIN       base launch speed, pixels/frame
//   CHARGE_MAX  charge saturation, frames (V_MIN + CHARGE_MAX <= 31)
//   PEAK_HOLD   zero-motion frames at the apex (1..15)
//   V_TERM      terminal fall speed, pixels/frame (1..31)
//
// Ports:
//   CLK         system clock
//   reset       synchronous, active-high reset
//   frame_tick  one-cycle pulse per video frame
//   space       level, high while the space key is held
//   on_ground   level, high while the character rests on the floor
//   y_motion    10-bit two's-complement Y step (negative = up), held between steps
//   step_valid  one-cycle pulse: position adds y_motion this cycle
//   land_pulse  one-cycle pulse on entry to LAND
//   busy        high whenever the sequencer is not IDLE
//   state_o     debug state: IDLE=0 CHARGE=1 RISE=2 PEAK=3 FALL=4 LAND=5
//   charge      current charge count
//------------------------------------------------------------------------------
module jump_sequencer #(
    parameter int V_MIN      = 4,
    parameter int CHARGE_MAX = 15,
    parameter int PEAK_HOLD  = 3,
    parameter int V_TERM     = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       space,
    input  logic       on_ground,
    output logic [9:0] y_motion,
    output logic       step_valid,
    output logic       land_pulse,
    output logic       busy,
    output logic [2:0] state_o,
    output logic [3:0] charge
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHARGE = 3'd1,
        RISE   = 3'd2,
        PEAK   = 3'd3,
        FALL   = 3'd4,
        LAND   = 3'd5
    } state_t;

    localparam logic [4:0] V_MIN_V     = 5'(V_MIN);
    localparam logic [4:0] V_TERM_V    = 5'(V_TERM);
    localparam logic [3:0] PEAK_HOLD_V = 4'(PEAK_HOLD);
`ifdef JUMP_CHARGE_EN
    localparam logic [3:0] CHARGE_MAX_V = 4'(CHARGE_MAX);
`endif

    // Reject parameter sets that would overflow the 5-bit speed or 4-bit counters.
    if (V_MIN < 0 || CHARGE_MAX < 0 || CHARGE_MAX > 15 || V_MIN + CHARGE_MAX > 31 ||
        PEAK_HOLD < 1 || PEAK_HOLD > 15 || V_TERM < 1 || V_TERM > 31) begin : g_bad_params
        $error("jump_sequencer: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [4:0] v_q, v_d;
    logic [3:0] charge_q, charge_d;
    logic [3:0] hold_q, hold_d;
    logic       space_q;
    logic       armed_q;
    logic [9:0] y_q, y_d;
    logic       step_q, step_d;
    logic       land_q, land_d;
    logic       busy_q;
    logic       space_rise;

    // armed_q stays low after reset until space has been seen released, so
    // a key held through reset cannot look like a fresh press.
    assign space_rise = space & ~space_q & armed_q;

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path through the logic can hold a value and infer a latch.
    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        charge_d = charge_q;
        hold_d   = hold_q;
        y_d      = y_q;
        step_d   = 1'b0;
        land_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (space_rise && on_ground) begin
`ifdef JUMP_CHARGE_EN
                    state_d  = CHARGE;
                    charge_d = 4'd0;
`else
                    state_d  = RISE;
                    v_d      = V_MIN_V;
`endif
                end else if (frame_tick && !on_ground) begin
                    // Walked off an edge: start falling, the first step comes on the next tick.
                    state_d = FALL;
                    v_d     = 5'd1;
                end
            end

`ifdef JUMP_CHARGE_EN
            CHARGE: begin
                // Release wins over a coincident tick: launch with the charge held so far.
                if (!space) begin
                    state_d = RISE;
                    v_d     = V_MIN_V + {1'b0, charge_q};
                end else if (frame_tick && charge_q < CHARGE_MAX_V) begin
                    charge_d = charge_q + 4'd1;
                end
            end
`endif

            RISE: begin
                if (frame_tick) begin
                    step_d = 1'b1;
                    y_d    = 10'd0 - {5'd0, v_q};
                    v_d    = v_q - 5'd1;
                    if (v_q <= 5'd1) begin
                        state_d = PEAK;
                        hold_d  = PEAK_HOLD_V;
                    end
                end
            end

            PEAK: begin
                if (frame_tick) begin
                    step_d = 1'b1;
                    y_d    = 10'd0;
                    hold_d = hold_q - 4'd1;
                    if (hold_q == 4'd1) begin
                        state_d = FALL;
                        v_d     = 5'd1;
                    end
                end
            end

            FALL: begin
                if (frame_tick) begin
                    if (on_ground) begin
                        state_d = LAND;
                        land_d  = 1'b1;
                    end else begin
                        step_d = 1'b1;
                        y_d    = {5'd0, v_q};
                        v_d    = (v_q >= V_TERM_V) ? V_TERM_V : v_q + 5'd1;
                    end
                end
            end

            LAND: begin
                if (frame_tick) begin
                    step_d   = 1'b1;
                    y_d      = 10'd0;
                    state_d  = IDLE;
                    v_d      = 5'd0;
                    charge_d = 4'd0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous here, matching the rest of the character datapath.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= IDLE;
            v_q      <= 5'd0;
            charge_q <= 4'd0;
            hold_q   <= 4'd0;
            space_q  <= 1'b0;
            armed_q  <= 1'b0;
            y_q      <= 10'd0;
            step_q   <= 1'b0;
            land_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            charge_q <= charge_d;
            hold_q   <= hold_d;
            space_q  <= space;
            armed_q  <= armed_q | ~space;
            y_q      <= y_d;
            step_q   <= step_d;
            land_q   <= land_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign y_motion   = y_q;
    assign step_valid = step_q;
    assign land_pulse = land_q;
    assign busy       = busy_q;
    assign state_o    = state_q;
    assign charge     = charge_q;

endmodule

// File: tb/tb_jump_sequencer.sv
//------------------------------------------------------------------------------
// tb_jump_sequencer
//
// Drives jump_sequencer through each of its scenarios and compares the stream
// of emitted Y steps against an arc computed from the jump rules. The rules
// are: rise from the launch speed down to 1, then PEAK_HOLD zero steps, then
// fall speeds 1, 2, ... capped at V_TERM, then one zero step after landing.
//------------------------------------------------------------------------------
module tb_jump_sequencer;

    localparam int V_MIN      = 4;
    localparam int CHARGE_MAX = 15;
    localparam int PEAK_HOLD  = 3;
    localparam int V_TERM     = 8;
`ifdef JUMP_CHARGE_EN
    localparam bit CHARGE_EN = 1'b1;
`else
    localparam bit CHARGE_EN = 1'b0;
`endif
    localparam logic [2:0] LAUNCH_ST = CHARGE_EN ? 3'd1 : 3'd2;

    logic       CLK = 1'b0;
    logic       reset, frame_tick, space, on_ground;
    logic [9:0] y_motion;
    logic       step_valid, land_pulse, busy;
    logic [2:0] state_o;
    logic [3:0] charge;

    int n_checks = 0;
    int n_fail   = 0;
    int max_gap  = 3;
    int step_q[$];
    int land_cnt = 0;
    int exp_q[$];
    int step_base, land_base;

    typedef struct {
        logic [2:0] st_press;
        logic [3:0] chg_seen;
        logic [2:0] st_rise;
        logic       busy_rise;
        logic [3:0] chg_rise;
        logic [2:0] st_land;
        logic       lp_land;
        logic       sv_land;
        logic [2:0] st_end;
        logic       busy_end;
        logic [9:0] y_end;
    } jump_obs_t;

    always #5 CLK = ~CLK;

    jump_sequencer #(
        .V_MIN(V_MIN), .CHARGE_MAX(CHARGE_MAX), .PEAK_HOLD(PEAK_HOLD), .V_TERM(V_TERM)
    ) dut (
        .CLK(CLK), .reset(reset), .frame_tick(frame_tick), .space(space),
        .on_ground(on_ground), .y_motion(y_motion), .step_valid(step_valid),
        .land_pulse(land_pulse), .busy(busy), .state_o(state_o), .charge(charge)
    );

    // Record every qualified step and landing, away from the active edge.
    always @(negedge CLK) begin
        if (step_valid) step_q.push_back(int'($signed(y_motion)));
        if (land_pulse) land_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int exp_charge(input int n);
        if (!CHARGE_EN) return 0;
        return (n < CHARGE_MAX) ? n : CHARGE_MAX;
    endfunction

    function automatic int launch_v(input int n);
        return V_MIN + exp_charge(n);
    endfunction

    task automatic build_arc(input int v0, input int n_fall);
        exp_q.delete();
        for (int v = v0; v >= 1; v--) exp_q.push_back(-v);
        repeat (PEAK_HOLD) exp_q.push_back(0);
        for (int k = 1; k <= n_fall; k++) exp_q.push_back((k < V_TERM) ? k : V_TERM);
        exp_q.push_back(0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        repeat ($urandom_range(max_gap, 0)) cycle();
    endtask

    // One complete jump from IDLE: press, n_chg charge frames, release,
    // fly the full arc with n_fall fall steps, land, and return to IDLE.
    task automatic do_jump(input int n_chg, input int n_fall, input bit rel_tick,
                           input bit wiggle, output jump_obs_t o);
        int v0;
        v0 = launch_v(n_chg);
        space = 1'b0; frame_tick = 1'b0; on_ground = 1'b1;
        cycle();
        step_base = step_q.size();
        land_base = land_cnt;
        space = 1'b1;
        cycle();
        o.st_press = state_o;
        for (int i = 0; i < (CHARGE_EN ? n_chg : 0); i++) tick();
        o.chg_seen = charge;
        space = 1'b0;
        frame_tick = rel_tick & CHARGE_EN;
        cycle();
        frame_tick = 1'b0;
        o.st_rise   = state_o;
        o.busy_rise = busy;
        o.chg_rise  = charge;
        on_ground = 1'b0;
        for (int i = 0; i < v0 + PEAK_HOLD + n_fall; i++) begin
            if (wiggle) begin
                space     = 1'($urandom_range(1, 0));
                on_ground = (i < v0) ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            tick();
        end
        space = 1'b0; on_ground = 1'b1; frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        o.st_land = state_o;
        o.lp_land = land_pulse;
        o.sv_land = step_valid;
        tick();
        cycle();
        o.st_end   = state_o;
        o.busy_end = busy;
        o.y_end    = y_motion;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; space = 1'b1; on_ground = 1'b1; frame_tick = 1'b0;
        repeat (3) begin
            frame_tick = ~frame_tick;
            cycle();
        end
        frame_tick = 1'b0;
        n_checks++;
        if ({y_motion, step_valid, land_pulse, busy, state_o, charge} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got y=%0d sv=%0b lp=%0b busy=%0b st=%0d chg=%0d, expected all 0",
                     y_motion, step_valid, land_pulse, busy, state_o, charge);
        end
        // Key held through reset, ground contact and ticks: nothing may start.
        reset = 1'b0;
        step_base = step_q.size();
        repeat (4) tick();
        cycle();
        n_checks++;
        if (state_o !== 3'd0 || busy !== 1'b0 || step_q.size() != step_base) begin
            n_fail++;
            $display("FAIL held space after reset: got state %0d busy %0b steps %0d, expected IDLE with no steps",
                     state_o, busy, step_q.size() - step_base);
        end
        space = 1'b0; cycle();
        space = 1'b1; cycle();
        n_checks++;
        if (state_o !== LAUNCH_ST) begin
            n_fail++;
            $display("FAIL re-press after reset: got state %0d expected %0d", state_o, LAUNCH_ST);
        end
        reset = 1'b1; space = 1'b0; cycle();
        reset = 1'b0; cycle();
    endtask

    task automatic test_basic_jump();
        jump_obs_t o;
        do_jump(2, 5, 1'b0, 1'b0, o);
        build_arc(launch_v(2), 5);
        n_checks++;
        if (o.st_press !== LAUNCH_ST) begin
            n_fail++; $display("FAIL basic launch state: got %0d expected %0d", o.st_press, LAUNCH_ST);
        end
        n_checks++;
        if (o.chg_seen !== 4'(exp_charge(2))) begin
            n_fail++; $display("FAIL basic charge: got %0d expected %0d", o.chg_seen, exp_charge(2));
        end
        n_checks++;
        if ({o.st_rise, o.busy_rise} !== {3'd2, 1'b1}) begin
            n_fail++; $display("FAIL basic rise entry: got state %0d busy %0b expected 2/1", o.st_rise, o.busy_rise);
        end
        n_checks++;
        if (step_q.size() - step_base != exp_q.size()) begin
            n_fail++; $display("FAIL basic step count: got %0d expected %0d", step_q.size() - step_base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (step_q[step_base + i] != exp_q[i]) begin
                n_fail++; $display("FAIL basic step %0d: got %0d expected %0d", i, step_q[step_base + i], exp_q[i]);
            end
        end
        n_checks++;
        if ({o.st_land, o.lp_land, o.sv_land} !== {3'd5, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL basic landing: got state %0d lp %0b sv %0b expected 5/1/0", o.st_land, o.lp_land, o.sv_land);
        end
        n_checks++;
        if ({o.st_end, o.busy_end, o.y_end} !== 14'd0 || land_cnt - land_base != 1) begin
            n_fail++; $display("FAIL basic end: got state %0d busy %0b y %0d lands %0d expected 0/0/0/1",
                               o.st_end, o.busy_end, o.y_end, land_cnt - land_base);
        end
    endtask

    task automatic test_charge_saturation();
        jump_obs_t o;
        do_jump(20, 3, 1'b0, 1'b0, o);
        build_arc(launch_v(20), 3);
        n_checks++;
        if (o.chg_seen !== 4'(exp_charge(20))) begin
            n_fail++; $display("FAIL saturation charge: got %0d expected %0d", o.chg_seen, exp_charge(20));
        end
        n_checks++;
        if (step_q.size() - step_base != exp_q.size()) begin
            n_fail++; $display("FAIL saturation step count: got %0d expected %0d", step_q.size() - step_base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (step_q[step_base + i] != exp_q[i]) begin
                n_fail++; $display("FAIL saturation step %0d: got %0d expected %0d", i, step_q[step_base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_release_with_tick();
        jump_obs_t o;
        do_jump(3, 2, 1'b1, 1'b1, o);
        build_arc(launch_v(3), 2);
        n_checks++;
        if (o.chg_rise !== 4'(exp_charge(3)) || o.st_rise !== 3'd2) begin
            n_fail++; $display("FAIL release+tick: got charge %0d state %0d expected %0d/2", o.chg_rise, o.st_rise, exp_charge(3));
        end
        n_checks++;
        if (step_q.size() - step_base != exp_q.size()) begin
            n_fail++; $display("FAIL release step count: got %0d expected %0d", step_q.size() - step_base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (step_q[step_base + i] != exp_q[i]) begin
                n_fail++; $display("FAIL release step %0d: got %0d expected %0d", i, step_q[step_base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_fall_from_idle();
        space = 1'b0; on_ground = 1'b1; frame_tick = 1'b0;
        cycle();
        step_base = step_q.size();
        land_base = land_cnt;
        on_ground = 1'b0; frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        n_checks++;
        if (state_o !== 3'd4 || step_valid !== 1'b0) begin
            n_fail++; $display("FAIL walk-off: got state %0d sv %0b expected 4/0", state_o, step_valid);
        end
        repeat (12) tick();
        repeat (2) cycle();
        n_checks++;
        if (y_motion !== 10'd8 || step_valid !== 1'b0) begin
            n_fail++; $display("FAIL y_motion hold: got y %0d sv %0b expected 8/0", y_motion, step_valid);
        end
        on_ground = 1'b1; frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        n_checks++;
        if ({state_o, land_pulse, step_valid} !== {3'd5, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL fall landing: got state %0d lp %0b sv %0b expected 5/1/0", state_o, land_pulse, step_valid);
        end
        cycle();
        n_checks++;
        if (land_pulse !== 1'b0) begin
            n_fail++; $display("FAIL land_pulse width: got %0b one cycle later, expected 0", land_pulse);
        end
        tick();
        cycle();
        exp_q.delete();
        for (int k = 1; k <= 12; k++) exp_q.push_back((k < V_TERM) ? k : V_TERM);
        exp_q.push_back(0);
        n_checks++;
        if (step_q.size() - step_base != exp_q.size()) begin
            n_fail++; $display("FAIL fall step count: got %0d expected %0d", step_q.size() - step_base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (step_q[step_base + i] != exp_q[i]) begin
                n_fail++; $display("FAIL fall step %0d: got %0d expected %0d", i, step_q[step_base + i], exp_q[i]);
            end
        end
        n_checks++;
        if (state_o !== 3'd0 || land_cnt - land_base != 1) begin
            n_fail++; $display("FAIL fall end: got state %0d lands %0d expected 0/1", state_o, land_cnt - land_base);
        end
    endtask

    task automatic test_reset_mid_rise();
        space = 1'b0; on_ground = 1'b1; frame_tick = 1'b0;
        cycle();
        step_base = step_q.size();
        space = 1'b1; cycle();
        space = 1'b0; cycle();
        on_ground = 1'b0;
        tick();
        tick();
        space = 1'b1; reset = 1'b1; on_ground = 1'b1; frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        n_checks++;
        if ({y_motion, step_valid, land_pulse, busy, state_o, charge} !== 20'd0) begin
            n_fail++; $display("FAIL mid-rise reset: got y=%0d sv=%0b lp=%0b busy=%0b st=%0d chg=%0d expected all 0",
                               y_motion, step_valid, land_pulse, busy, state_o, charge);
        end
        n_checks++;
        if (step_q.size() - step_base != 2 || step_q[step_q.size() - 1] != -(V_MIN - 1)) begin
            n_fail++; $display("FAIL mid-rise steps: got %0d steps, last %0d, expected 2 steps ending %0d",
                               step_q.size() - step_base, step_q[step_q.size() - 1], -(V_MIN - 1));
        end
        reset = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (state_o !== 3'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL held through mid-rise reset: got state %0d busy %0b expected 0/0", state_o, busy);
        end
        reset = 1'b1; space = 1'b0; cycle();
        reset = 1'b0; cycle();
    endtask

    task automatic test_back_to_back();
        jump_obs_t o;
        max_gap = 0;
        do_jump(1, 4, 1'b0, 1'b0, o);
        max_gap = 3;
        build_arc(launch_v(1), 4);
        n_checks++;
        if (step_q.size() - step_base != exp_q.size()) begin
            n_fail++; $display("FAIL back-to-back step count: got %0d expected %0d", step_q.size() - step_base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (step_q[step_base + i] != exp_q[i]) begin
                n_fail++; $display("FAIL back-to-back step %0d: got %0d expected %0d", i, step_q[step_base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_jumps();
        jump_obs_t o;
        for (int it = 0; it < 6; it++) begin
            int n_chg, n_fall;
            bit rel;
            n_chg  = int'($urandom_range(20, 0));
            n_fall = int'($urandom_range(12, 0));
            rel    = 1'($urandom_range(1, 0));
            do_jump(n_chg, n_fall, rel, 1'b1, o);
            build_arc(launch_v(n_chg), n_fall);
            n_checks++;
            if (o.st_press !== LAUNCH_ST || o.chg_rise !== 4'(exp_charge(n_chg))) begin
                n_fail++; $display("FAIL random[%0d] launch: got state %0d charge %0d expected %0d/%0d",
                                   it, o.st_press, o.chg_rise, LAUNCH_ST, exp_charge(n_chg));
            end
            n_checks++;
            if (step_q.size() - step_base != exp_q.size()) begin
                n_fail++; $display("FAIL random[%0d] step count: got %0d expected %0d", it, step_q.size() - step_base, exp_q.size());
            end else foreach (exp_q[i]) begin
                n_checks++;
                if (step_q[step_base + i] != exp_q[i]) begin
                    n_fail++; $display("FAIL random[%0d] step %0d: got %0d expected %0d", it, i, step_q[step_base + i], exp_q[i]);
                end
            end
            n_checks++;
            if (o.lp_land !== 1'b1 || o.st_end !== 3'd0 || land_cnt - land_base != 1) begin
                n_fail++; $display("FAIL random[%0d] landing: got lp %0b end state %0d lands %0d expected 1/0/1",
                                   it, o.lp_land, o.st_end, land_cnt - land_base);
            end
        end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; space = 1'b0; on_ground = 1'b1;
        test_reset();
        test_basic_jump();
        test_charge_saturation();
        test_release_with_tick();
        test_fall_from_idle();
        test_reset_mid_rise();
        test_back_to_back();
        test_random_jumps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
